execute_cycle: RTL
==================

# execute_cycle

Execute stage of the 5-stage RV32 pipeline, directly downstream of the decode stage. It consumes the ID/EX register outputs, applies hazard-unit forwarding, runs the ALU, and resolves branches. It also contains an iterative multiply / multiply-accumulate unit that stalls the front end while it runs, and it owns the EX/MEM pipeline register.

## Interface
Parameters:
- RADIX_BITS, 2, multiplier bits retired per iteration; legal values 1, 2, 4; K = 32/RADIX_BITS iterations.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  decoded controls
- ALUControlE  in  6  operation code
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands / PC values
- RD_E  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  00 = RDx_E, 01 = ResultW, 10 = ALUResultM, 11 = RDx_E
- ResultW  in  32  writeback value
- FlushE  in  1  synchronous kill of the instruction in E
- StallE  out  1  upstream must hold F/D and ID/EX
- PCSrcE  out  1  branch taken
- PCTargetE  out  32  PCE + Imm_Ext_E
- RegWriteM, MemWriteM, ResultSrcM  out  1 each
- RD_M  out  5
- ALUResultM, WriteDataM, PCPlus4M  out  32 each

## Operation
- SrcA = forwarded A. WriteData = forwarded B. SrcB = Imm_Ext_E if ALUSrcE, else forwarded B.
- ALUControlE codes:
  - 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR
  - 05 SLT (signed, result 0/1)
  - 06 SLL, 07 SRL (shift amount SrcB[4:0])
  - 08 MUL, 09 MAC, 0A MACCLR, 0B MACRD
  - any other code: result 0.
- All arithmetic is modulo 2^32. The product is the low 32 bits of SrcA*SrcB (unsigned).
- MAC: acc <= acc + product; result = new acc.
- MACCLR: acc <= 0; result 0; single cycle.
- MACRD: result = acc; single cycle.
- ZeroE = (ALU result == 0). PCSrcE = BranchE & ZeroE & ~StallE & ~FlushE.
- Multiplier FSM:
  - IDLE: an op 08/09 with FlushE=0 captures SrcA/SrcB, clears the partial product and counter, and goes to BUSY. StallE is 1 in that cycle (combinational).
  - BUSY: each cycle adds (multiplicand << shift) × RADIX_BITS-bit multiplier digit. After K iterations, go to DONE. StallE=1.
  - DONE: StallE=0. Result is selected into EX/MEM. The MAC acc update happens at this edge. Return to IDLE.
- EX/MEM register:
  - Loads each cycle.
  - Loads a bubble (RegWriteM=MemWriteM=ResultSrcM=0, RD_M=0, data 0) when FlushE=1 or StallE=1.
  - Otherwise loads the E-stage values.
- FlushE in BUSY or DONE aborts the operation: go to IDLE, load a bubble, leave acc unchanged.

## Timing
- Single-cycle ops: result appears on ALUResultM one edge after the cycle in E.
- MUL/MAC first in E at t0:
  - StallE=1 during t0..tK (K+1 cycles).
  - DONE at tK+1.
  - Result valid on ALUResultM after the tK+1 edge.
  - RADIX_BITS=2: 17 stall cycles.
- Operands are frozen at t0. Forward select changes during BUSY have no effect.
- PCTargetE, PCSrcE and StallE are combinational.
- Reset values:
  - All M-stage outputs 0; acc 0; FSM IDLE.
  - StallE 0 (ID/EX reset contents decode as ADD), PCSrcE 0.
- Reset asserted mid-multiply: immediate return to IDLE, acc cleared.
- Back-to-back MUL: the second MUL enters E after DONE and starts at IDLE the next cycle. There are no idle gaps beyond that.

## Configuration
- EXECUTE_MAC_EN defined: multiplier FSM and accumulator are present, and codes 08–0B behave as above.
- EXECUTE_MAC_EN undefined:
  - No FSM and no acc.
  - Codes 08–0B produce result 0 in a single cycle.
  - StallE tied to 0.

## Test plan
- Reset: hold rst=0 with ADD stimulus on the inputs → all M outputs 0, StallE 0. After release, ADD 5+7 → ALUResultM=12 and RegWriteM=1 after one edge.
- Forwarding: ForwardAE=10 with ALUResultM=0x10, ForwardBE=01 with ResultW=3, op SUB → ALUResultM=0x0D. WriteDataM=3.
- Branch: BranchE=1, SUB with RD1=RD2=9 → PCSrcE=1, PCTargetE=PCE+Imm (0x100+0x20=0x120). With FlushE=1 → PCSrcE=0 and a bubble is loaded.
- MUL (RADIX_BITS=2): 0xFFFF_FFFF×3 → StallE high 17 cycles, bubbles in M throughout, then ALUResultM=0xFFFF_FFFD.
- MAC sequence: MACCLR; MAC 6×7; MAC 2×5; MACRD → results 0, 42, 52, 52.
- Abort: MAC 4×4 with FlushE pulsed mid-BUSY → bubble loaded, StallE drops the next cycle, a following MACRD returns the prior acc value. A reset pulse mid-BUSY → MACRD returns 0.

Source files
------------

// File: rtl/execute_cycle.sv
// execute_cycle: RV32 EX stage with forwarding, ALU, branch resolve and EX/MEM register.
// EXECUTE_MAC_EN adds the iterative MUL/MAC unit and accumulator.
module execute_cycle #(
  parameter int RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [5:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        StallE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_SUB    = 6'h01;
  localparam logic [5:0] OP_AND    = 6'h02;
  localparam logic [5:0] OP_OR     = 6'h03;
  localparam logic [5:0] OP_XOR    = 6'h04;
  localparam logic [5:0] OP_SLT    = 6'h05;
  localparam logic [5:0] OP_SLL    = 6'h06;
  localparam logic [5:0] OP_SRL    = 6'h07;
  localparam logic [5:0] OP_MUL    = 6'h08;
  localparam logic [5:0] OP_MAC    = 6'h09;
  localparam logic [5:0] OP_MACCLR = 6'h0A;
  localparam logic [5:0] OP_MACRD  = 6'h0B;

  logic [31:0] src_a, fwd_b, src_b;
  logic [31:0] alu_y, result_e, mac_rd, mul_y;
  logic        stall, done;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

`ifdef EXECUTE_MAC_EN
  localparam int         K     = 32 / RADIX_BITS;
  localparam logic [5:0] KLAST = 6'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mac_q, mac_d;
  logic [31:0] pp;
  logic        is_mul, start;

  assign is_mul = (ALUControlE == OP_MUL) || (ALUControlE == OP_MAC);
  assign start  = (state_q == S_IDLE) && is_mul && !FlushE;
  assign stall  = start || (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign mul_y  = mac_q ? acc_q + prod_q : prod_q;
  assign mac_rd = acc_q;

  // one multiplier digit times the pre-shifted multiplicand
  always_comb begin
    pp = '0;
    for (int b = 0; b < RADIX_BITS; b++)
      if (mplier_q[b]) pp = pp + (mcand_q << b);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mac_d    = mac_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BUSY;
          mcand_d  = src_a;
          mplier_d = src_b;
          prod_d   = '0;
          cnt_d    = '0;
          mac_d    = (ALUControlE == OP_MAC);
        end else if (!FlushE && ALUControlE == OP_MACCLR) begin
          acc_d = '0;
        end
      end
      S_BUSY: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          prod_d   = prod_q + pp;
          mcand_d  = mcand_q << RADIX_BITS;
          mplier_d = mplier_q >> RADIX_BITS;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == KLAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!FlushE && mac_q) acc_d = mul_y;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mac_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
    end
  end
`else
  assign stall  = 1'b0;
  assign done   = 1'b0;
  assign mul_y  = '0;
  assign mac_rd = '0;
`endif

  always_comb begin
    alu_y = '0;
    case (ALUControlE)
      OP_ADD:   alu_y = src_a + src_b;
      OP_SUB:   alu_y = src_a - src_b;
      OP_AND:   alu_y = src_a & src_b;
      OP_OR:    alu_y = src_a | src_b;
      OP_XOR:   alu_y = src_a ^ src_b;
      OP_SLT:   alu_y = {31'b0, $signed(src_a) < $signed(src_b)};
      OP_SLL:   alu_y = src_a << src_b[4:0];
      OP_SRL:   alu_y = src_a >> src_b[4:0];
      OP_MACRD: alu_y = mac_rd;
      default:  alu_y = '0;
    endcase
  end

  assign result_e  = done ? mul_y : alu_y;
  assign StallE    = stall;
  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = BranchE & (result_e == 32'h0) & ~stall & ~FlushE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (FlushE || stall) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= result_e;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule
